control_sequencer_p: RTL and testbench

//  Parametrised fetch/decode/execute control unit for the accumulator processor.

---
 rtl/control_sequencer_p.sv | 242 ++++++++++++++++++++++++
 tb/tb_control_sequencer_p.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_p.sv
// Fetch/decode/execute control FSM for the accumulator CPU; ILLEGAL_TRAP_EN makes opcodes C-E trap to HALT.
// Latency: 4 cycles per register/NOP instruction; operand and memory phases add cycles.
// Backpressure: mem_read/mem_write are held and the FSM stalls until mem_ready.
module control_sequencer_p #(
  parameter int OPC_W  = 6,
  parameter int NREG   = 4,
  parameter int ABUS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [OPC_W-1:0]  ir,
  input  logic              z_flag,
  input  logic              mem_ready,
  output logic [ABUS_W-1:0] a_bus_sel,
  output logic [NREG+3:0]   c_bus,
  output logic [2:0]        alu_op,
  output logic              ldir,
  output logic              pc_inc,
  output logic              ac_inc,
  output logic [NREG-1:0]   reg_inc,
  output logic              mem_read,
  output logic              mem_write,
  output logic              halted,
  output logic              illegal
);

  localparam int RF_W = OPC_W - 4;
  localparam logic [RF_W:0] NREG_L = (RF_W+1)'(NREG);

  localparam logic [3:0] OP_LDAC  = 4'h1;
  localparam logic [3:0] OP_STAC  = 4'h2;
  localparam logic [3:0] OP_MVAC  = 4'h3;
  localparam logic [3:0] OP_MVR   = 4'h4;
  localparam logic [3:0] OP_ADD   = 4'h5;
  localparam logic [3:0] OP_SUB   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_INC   = 4'h8;
  localparam logic [3:0] OP_INCAC = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_JMPZ  = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [ABUS_W-1:0] AS_PC = ABUS_W'(1);
  localparam logic [ABUS_W-1:0] AS_DR = ABUS_W'(2);
  localparam logic [ABUS_W-1:0] AS_AC = ABUS_W'(3);

  localparam int CB_AR = 0;
  localparam int CB_PC = 1;
  localparam int CB_DR = 2;
  localparam int CB_AC = 3;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCH1,
    S_DECODE,
    S_OPND0,
    S_OPND1,
    S_MEM0,
    S_MEM1,
    S_EXEC,
    S_HALT
  } state_e;

  state_e state_q, state_d;
  logic   z_q, z_d;

  logic [3:0]        opc;
  logic [RF_W-1:0]   rsel;
  logic              reg_ok;
  logic [NREG-1:0]   reg_oh;
  logic [ABUS_W-1:0] reg_src;
  logic              needs_opnd;
  logic              is_mem_op;

  assign opc     = ir[OPC_W-1:OPC_W-4];
  assign rsel    = ir[RF_W-1:0];
  assign reg_ok  = ({1'b0, rsel} < NREG_L);
  // An out-of-range register field yields an empty one-hot, so the instruction degenerates to a NOP.
  assign reg_oh  = reg_ok ? (NREG'(1) << rsel) : '0;
  assign reg_src = ABUS_W'(4) + ABUS_W'(rsel);

  assign is_mem_op  = (opc == OP_LDAC) || (opc == OP_STAC);
  assign needs_opnd = is_mem_op || (opc == OP_JMP) || ((opc == OP_JMPZ) && z_flag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    z_d       = z_q;
    a_bus_sel = '0;
    c_bus     = '0;
    alu_op    = ALU_PASS;
    ldir      = 1'b0;
    pc_inc    = 1'b0;
    ac_inc    = 1'b0;
    reg_inc   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    halted    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH0;
      end

      S_FETCH0: begin
        a_bus_sel    = AS_PC;
        c_bus[CB_AR] = 1'b1;
        state_d      = S_FETCH1;
      end

      S_FETCH1: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ldir    = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // The zero flag is captured here so JMPZ resolves on the flag present at decode.
        z_d = z_flag;
        if (opc == OP_HALT) begin
          state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
        end else if (opc inside {4'hC, 4'hD, 4'hE}) begin
          illegal = 1'b1;
          state_d = S_HALT;
`endif
        end else if (needs_opnd) begin
          state_d = S_OPND0;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_OPND0: begin
        a_bus_sel    = AS_PC;
        c_bus[CB_AR] = 1'b1;
        state_d      = S_OPND1;
      end

      S_OPND1: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          c_bus[CB_DR] = 1'b1;
          pc_inc       = 1'b1;
          state_d      = is_mem_op ? S_MEM0 : S_EXEC;
        end
      end

      S_MEM0: begin
        a_bus_sel    = AS_DR;
        c_bus[CB_AR] = 1'b1;
        state_d      = S_MEM1;
      end

      S_MEM1: begin
        if (opc == OP_STAC) begin
          a_bus_sel = AS_AC;
          mem_write = 1'b1;
          if (mem_ready) state_d = S_FETCH0;
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            c_bus[CB_DR] = 1'b1;
            state_d      = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        state_d = S_FETCH0;
        case (opc)
          OP_LDAC: begin
            a_bus_sel    = AS_DR;
            alu_op       = ALU_PASS;
            c_bus[CB_AC] = 1'b1;
          end
          OP_MVAC: begin
            if (reg_ok) begin
              a_bus_sel = AS_AC;
              c_bus     = {reg_oh, 4'b0000};
            end
          end
          OP_MVR, OP_ADD, OP_SUB, OP_AND: begin
            if (reg_ok) begin
              a_bus_sel    = reg_src;
              c_bus[CB_AC] = 1'b1;
              case (opc)
                OP_ADD:  alu_op = ALU_ADD;
                OP_SUB:  alu_op = ALU_SUB;
                OP_AND:  alu_op = ALU_AND;
                default: alu_op = ALU_PASS;
              endcase
            end
          end
          OP_INC:   reg_inc = reg_oh;
          OP_INCAC: ac_inc  = 1'b1;
          OP_JMP: begin
            a_bus_sel    = AS_DR;
            c_bus[CB_PC] = 1'b1;
          end
          OP_JMPZ: begin
            // Not-taken branch only steps the PC past the unread operand word.
            if (z_q) begin
              a_bus_sel    = AS_DR;
              c_bus[CB_PC] = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
          default: ;
        endcase
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer_p.sv
// Directed bench for control_sequencer_p: expected per-cycle outputs are queued by the stimulus
// and compared by an independent negedge monitor.
module tb_control_sequencer_p;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [5:0] ir;
  logic       z_flag;
  logic       mem_ready;
  logic [3:0] a_bus_sel;
  logic [7:0] c_bus;
  logic [2:0] alu_op;
  logic       ldir, pc_inc, ac_inc;
  logic [3:0] reg_inc;
  logic       mem_read, mem_write, halted, illegal;

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] c;
    logic [2:0] alu;
    logic       ldir;
    logic       pc_inc;
    logic       ac_inc;
    logic [3:0] rinc;
    logic       mrd;
    logic       mwr;
    logic       halted;
    logic       illegal;
  } out_t;

  localparam out_t Z = '0;

  out_t  act;
  out_t  e;
  out_t  m_e;
  string m_n;
  out_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;

  always #5 clk = ~clk;

  control_sequencer_p #(.OPC_W(6), .NREG(4), .ABUS_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir), .z_flag(z_flag), .mem_ready(mem_ready),
    .a_bus_sel(a_bus_sel), .c_bus(c_bus), .alu_op(alu_op), .ldir(ldir), .pc_inc(pc_inc),
    .ac_inc(ac_inc), .reg_inc(reg_inc), .mem_read(mem_read), .mem_write(mem_write),
    .halted(halted), .illegal(illegal)
  );

  assign act = {a_bus_sel, c_bus, alu_op, ldir, pc_inc, ac_inc, reg_inc,
                mem_read, mem_write, halted, illegal};

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      m_e = exp_q.pop_front();
      m_n = name_q.pop_front();
      checks++;
      if (act !== m_e)
        $display("FAIL %s: got %h required %h", m_n, act, m_e);
      else
        passes++;
    end
  end

  function automatic out_t mk(input logic [3:0] a, input logic [7:0] c, input logic [2:0] alu);
    out_t r;
    r = '0;
    r.a = a;
    r.c = c;
    r.alu = alu;
    return r;
  endfunction

  task automatic step(input string n, input out_t x);
    exp_q.push_back(x);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string p);
    out_t f;
    mem_ready = 1'b1;
    step({p, "_f0"}, mk(4'd1, 8'h01, 3'd0));
    f = Z; f.mrd = 1'b1; f.ldir = 1'b1; f.pc_inc = 1'b1;
    step({p, "_f1"}, f);
    step({p, "_dec"}, Z);
  endtask

  task automatic operand(input string p);
    out_t f;
    step({p, "_op0"}, mk(4'd1, 8'h01, 3'd0));
    f = Z; f.mrd = 1'b1; f.c = 8'h04; f.pc_inc = 1'b1;
    step({p, "_op1"}, f);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ir = '0; z_flag = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset0", Z);
    step("reset1", Z);
    rst_n = 1'b1;
    step("idle_norun", Z);
    run = 1'b1;
    step("idle_run", Z);
    run = 1'b0;

    // NOP loop, 4 cycles per instruction
    ir = 6'b000000;
    fetch("nop_a"); step("nop_a_ex", Z);
    fetch("nop_b"); step("nop_b_ex", Z);

    // FETCH1 stall
    mem_ready = 1'b0;
    step("wait_f0", mk(4'd1, 8'h01, 3'd0));
    e = Z; e.mrd = 1'b1;
    for (int i = 0; i < 3; i++) step("wait_f1_stall", e);
    mem_ready = 1'b1; e.ldir = 1'b1; e.pc_inc = 1'b1;
    step("wait_f1_rdy", e);
    step("wait_dec", Z);
    step("wait_ex", Z);

    // register instructions
    ir = 6'b010110; fetch("add_r2"); step("add_r2_ex", mk(4'd6, 8'h08, 3'd1));
    ir = 6'b011001; fetch("sub_r1"); step("sub_r1_ex", mk(4'd5, 8'h08, 3'd2));
    ir = 6'b011111; fetch("and_r3"); step("and_r3_ex", mk(4'd7, 8'h08, 3'd3));
    ir = 6'b001101; fetch("mvac_r1"); step("mvac_r1_ex", mk(4'd3, 8'h20, 3'd0));
    ir = 6'b010000; fetch("mvr_r0"); step("mvr_r0_ex", mk(4'd4, 8'h08, 3'd0));
    ir = 6'b100011; fetch("inc_r3"); e = Z; e.rinc = 4'b1000; step("inc_r3_ex", e);
    ir = 6'b100100; fetch("incac"); e = Z; e.ac_inc = 1'b1; step("incac_ex", e);

    // JMPZ not taken / taken (flag changes after decode must not matter)
    ir = 6'b101100; z_flag = 1'b0;
    fetch("jmpz0"); z_flag = 1'b1;
    e = Z; e.pc_inc = 1'b1; step("jmpz0_ex", e);
    z_flag = 1'b1;
    fetch("jmpz1"); z_flag = 1'b0;
    step("jmpz1_op0", mk(4'd1, 8'h01, 3'd0));
    mem_ready = 1'b0; e = Z; e.mrd = 1'b1;
    step("jmpz1_op1_stall", e);
    mem_ready = 1'b1; e.c = 8'h04; e.pc_inc = 1'b1;
    step("jmpz1_op1_rdy", e);
    step("jmpz1_ex", mk(4'd2, 8'h02, 3'd0));

    // LDAC
    ir = 6'b000100;
    fetch("ldac"); operand("ldac");
    step("ldac_mem0", mk(4'd2, 8'h01, 3'd0));
    e = Z; e.mrd = 1'b1; e.c = 8'h04;
    step("ldac_mem1", e);
    step("ldac_ex", mk(4'd2, 8'h08, 3'd0));

    // STAC with a write stall, then straight back to FETCH0
    ir = 6'b001000;
    fetch("stac"); operand("stac");
    step("stac_mem0", mk(4'd2, 8'h01, 3'd0));
    mem_ready = 1'b0; e = mk(4'd3, 8'h00, 3'd0); e.mwr = 1'b1;
    step("stac_mem1_stall", e);
    mem_ready = 1'b1;
    step("stac_mem1_rdy", e);
    step("stac_next_f0", mk(4'd1, 8'h01, 3'd0));

    // HALT is sticky against run
    ir = 6'b111100;
    e = Z; e.mrd = 1'b1; e.ldir = 1'b1; e.pc_inc = 1'b1;
    step("halt_f1", e);
    step("halt_dec", Z);
    e = Z; e.halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      step("halted_hold", e);
    end
    rst_n = 1'b0;
    step("halt_rst", Z);
    step("halt_rst2", Z);
    rst_n = 1'b1; run = 1'b0;
    step("post_rst_idle", Z);

    // opcode C
    run = 1'b1;
    step("ill_idle_run", Z);
    run = 1'b0; ir = 6'b110000;
    step("ill_f0", mk(4'd1, 8'h01, 3'd0));
    e = Z; e.mrd = 1'b1; e.ldir = 1'b1; e.pc_inc = 1'b1;
    step("ill_f1", e);
`ifdef ILLEGAL_TRAP_EN
    e = Z; e.illegal = 1'b1;
    step("ill_dec", e);
    e = Z; e.halted = 1'b1;
    step("ill_halt", e);
    step("ill_halt2", e);
`else
    step("ill_dec", Z);
    step("ill_ex", Z);
    step("ill_next_f0", mk(4'd1, 8'h01, 3'd0));
`endif

    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    else
      passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
